// File: rtl/ring_measure_pkg.sv
// rtl/ring_measure_pkg.sv - shared state encoding and default sizes for the ring-oscillator edge counter
package ring_measure_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2
  } state_t;

  localparam int DEF_COUNT_W       = 32;
  localparam int DEF_WINDOW_W      = 32;
  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/ring_edge_sync.sv
// rtl/ring_edge_sync.sv - synchroniser chain for the asynchronous ring input plus rising-edge pulse
module ring_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/ring_osc_edge_counter.sv
// rtl/ring_osc_edge_counter.sv - gates the adder ring, counts its edges over a window; SATURATE_EN selects saturating count
module ring_osc_edge_counter
  import ring_measure_pkg::*;
#(
  parameter int COUNT_W       = DEF_COUNT_W,
  parameter int WINDOW_W      = DEF_WINDOW_W,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window_cycles,
  input  logic                ring_in,
  output logic                ring_enable,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count_out,
  output logic                overflow
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

  state_t              state, state_nxt;
  logic [SET_W-1:0]    settle_cnt;
  logic [WINDOW_W-1:0] win_cnt;
  logic [COUNT_W-1:0]  edge_cnt, cnt_nxt;
  logic                ovf_flag, ovf_nxt;
  logic                edge_pulse;
  logic                accept, arm_last, count_last, finish;

  ring_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (wb_clk_i),
    .rst_n    (wb_rst_n),
    .async_in (ring_in),
    .rise     (edge_pulse)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    arm_last    = 1'b0;
    count_last  = 1'b0;
    ring_enable = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          accept    = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        ring_enable = 1'b1;
        busy        = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle_cnt == SET_W'(1)) begin
          arm_last  = 1'b1;
          state_nxt = (win_cnt == '0) ? IDLE : COUNT;
        end
      end
      COUNT: begin
        ring_enable = 1'b1;
        busy        = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (win_cnt == WINDOW_W'(1)) begin
          count_last = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign finish = (arm_last && (win_cnt == '0)) || count_last;

  // the edge seen in the final window cycle must land in count_out, hence the next-value path
  always_comb begin
    cnt_nxt = edge_cnt;
    ovf_nxt = ovf_flag;
    if (state == COUNT && edge_pulse) begin
`ifdef SATURATE_EN
      if (&edge_cnt) ovf_nxt = 1'b1;
      else           cnt_nxt = edge_cnt + COUNT_W'(1);
`else
      cnt_nxt = edge_cnt + COUNT_W'(1);
      if (&edge_cnt) ovf_nxt = 1'b1;
`endif
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      done       <= 1'b0;
      count_out  <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        count_out <= cnt_nxt;
        overflow  <= ovf_nxt;
      end
      if (accept) begin
        settle_cnt <= SET_W'(SETTLE_CYCLES);
        win_cnt    <= window_cycles;
        edge_cnt   <= '0;
        ovf_flag   <= 1'b0;
      end else begin
        if (state == ARM)   settle_cnt <= settle_cnt - SET_W'(1);
        if (state == COUNT) win_cnt    <= win_cnt - WINDOW_W'(1);
        edge_cnt <= cnt_nxt;
        ovf_flag <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ring_osc_edge_counter.sv
// tb/tb_ring_osc_edge_counter.sv - directed and randomized bench for ring_osc_edge_counter
module tb_ring_osc_edge_counter;

  localparam int CW   = 4;
  localparam int WW   = 16;
  localparam int S    = 4;
  localparam int SMAX = 8192;

  logic          wb_clk_i;
  logic          wb_rst_n;
  logic          start;
  logic          abort;
  logic [WW-1:0] window_cycles;
  logic          ring_in;
  logic          ring_enable;
  logic          busy;
  logic          done;
  logic [CW-1:0] count_out;
  logic          overflow;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit samp [0:SMAX-1];
  int ring_mode = 0;
  int half      = 4;
  int last_cnt  = 0;
  bit last_ovf  = 0;

  ring_osc_edge_counter #(
    .COUNT_W(CW), .WINDOW_W(WW), .SETTLE_CYCLES(S), .SYNC_STAGES(2)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_n      (wb_rst_n),
    .start         (start),
    .abort         (abort),
    .window_cycles (window_cycles),
    .ring_in       (ring_in),
    .ring_enable   (ring_enable),
    .busy          (busy),
    .done          (done),
    .count_out     (count_out),
    .overflow      (overflow)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  // ring sample history seen at each clock edge, indexed by edge number
  initial begin
    for (int i = 0; i < SMAX; i++) samp[i] = 1'b0;
    forever begin
      @(posedge wb_clk_i);
      cyc = cyc + 1;
      if (cyc < SMAX) samp[cyc] = ring_in;
    end
  end

  // ring stimulus: 0 hold low, 1 square wave, 2 random dwell, 3 manual
  initial begin
    int ph;
    int dwell;
    ph = 0;
    dwell = 3;
    ring_in = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      case (ring_mode)
        0: ring_in = 1'b0;
        1: begin
          if (ph >= half - 1) begin ring_in = ~ring_in; ph = 0; end
          else ph++;
        end
        2: begin
          if (dwell == 0) begin ring_in = ~ring_in; dwell = $urandom_range(2, 7); end
          else dwell--;
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // rising edges first sampled at edge e reach the counter two edges later (sync depth)
  function automatic int exp_rises(input int k, input int n);
    int c;
    c = 0;
    for (int e = k + S - 1; e <= k + S + n - 2; e++)
      if (e > 0 && e < SMAX && samp[e] && !samp[e-1]) c++;
    return c;
  endfunction

  // called at a negedge; drives start immediately
  task automatic measure(input int n, input int restart_at, input int abort_at,
                         input int rise_at, input string tag);
    int s, k, en_cnt, lat, c, ecnt, dseen;
    bit seen, eovf;
    s = cyc;
    k = s + 1;
    start = 1'b1;
    window_cycles = WW'(n);
    en_cnt = 0; lat = -1; seen = 0; dseen = 0;
    for (int i = 1; i <= n + S + 40; i++) begin
      @(negedge wb_clk_i);
      if (done) begin
        dseen++;
        if (!seen) begin seen = 1; lat = cyc - s; end
      end else if (!seen && ring_enable) en_cnt++;
      if (abort_at >= 0 && i == abort_at + 1) begin
        check({tag, "_en_after_abort"}, ring_enable, 0);
        check({tag, "_busy_after_abort"}, busy, 0);
      end
      start = (i == restart_at);
      if (i == restart_at) window_cycles = WW'(7);
      abort = (i == abort_at);
      if (i == rise_at) ring_in = 1'b1;
      if (seen && abort_at < 0) break;
    end
    start = 1'b0;
    abort = 1'b0;
    if (abort_at >= 0) begin
      check({tag, "_no_done"}, dseen, 0);
      check({tag, "_count_kept"}, count_out, last_cnt);
      check({tag, "_ovf_kept"}, overflow, last_ovf);
    end else begin
      c = exp_rises(k, n);
`ifdef SATURATE_EN
      ecnt = (c > 15) ? 15 : c;
`else
      ecnt = c % 16;
`endif
      eovf = (c > 15);
      check({tag, "_done_seen"}, seen, 1);
      check({tag, "_latency"}, lat, 1 + S + n);
      check({tag, "_enable_cycles"}, en_cnt, S + n);
      check({tag, "_count"}, count_out, ecnt);
      check({tag, "_overflow"}, overflow, eovf);
      last_cnt = ecnt;
      last_ovf = eovf;
    end
  endtask

  initial begin
    wb_rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    window_cycles = '0;
    repeat (3) @(negedge wb_clk_i);
    check("rst_ring_enable", ring_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", count_out, 0);
    check("rst_overflow", overflow, 0);
    wb_rst_n = 1'b1;
    repeat (3) @(negedge wb_clk_i);

    ring_mode = 1; half = 4;
    repeat (5) @(negedge wb_clk_i);
    measure(80, -1, -1, -1, "t1");
    check("t1_count_10", count_out, 10);

    // started in the done cycle of the previous run
    measure(0, -1, -1, -1, "t2");
    check("t2_count_0", count_out, 0);
    check("t2_ovf_0", overflow, 0);

    repeat (3) @(negedge wb_clk_i);
    measure(80, 15, -1, -1, "t3_restart");
    repeat (3) @(negedge wb_clk_i);
    measure(80, -1, 40, -1, "t3_abort");

    start = 1'b1; abort = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0; abort = 1'b0;
    check("t3_abort_wins", busy, 0);

    half = 2;
    repeat (5) @(negedge wb_clk_i);
    measure(80, -1, -1, -1, "t4");
`ifdef SATURATE_EN
    check("t4_count_sat", count_out, 15);
`else
    check("t4_count_wrap", count_out, 4);
`endif
    check("t4_ovf", overflow, 1);

    half = 4;
    repeat (2) @(negedge wb_clk_i);
    start = 1'b1; window_cycles = WW'(80);
    @(negedge wb_clk_i);
    start = 1'b0;
    repeat (20) @(negedge wb_clk_i);
    wb_rst_n = 1'b0;
    #1;
    check("t5_async_en", ring_enable, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_done", done, 0);
    check("t5_async_count", count_out, 0);
    check("t5_async_ovf", overflow, 0);
    ring_mode = 0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_n = 1'b1;
    last_cnt = 0; last_ovf = 0;
    repeat (8) @(negedge wb_clk_i);
    ring_mode = 1;
    repeat (3) @(negedge wb_clk_i);
    measure(40, -1, -1, -1, "t5_after");

    ring_mode = 0;
    repeat (5) @(negedge wb_clk_i);
    measure(30, -1, -1, -1, "t6_low");
    check("t6_low_count", count_out, 0);
    check("t6_low_ovf", overflow, 0);
    ring_mode = 3;
    repeat (3) @(negedge wb_clk_i);
    measure(20, -1, -1, 1, "t6_arm");
    check("t6_arm_count", count_out, 0);
    ring_mode = 0;

    ring_mode = 2;
    repeat (10) @(negedge wb_clk_i);
    for (int r = 0; r < 10; r++) begin
      int n;
      n = $urandom_range(1, 90);
      measure(n, -1, -1, -1, $sformatf("t7_r%0d", r));
    end

    repeat (4) @(negedge wb_clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
